// File: rtl/calc_entry_ctrl.sv
// Keypad-entry controller feeding a combinational add/sub unit: builds two decimal
// operands from key presses, launches one add or subtract, and holds the result for display.
module calc_entry_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             key_valid_i,
    input  logic [3:0]       key_code_i,
    output logic             key_ready_o,
    output logic [WIDTH-1:0] add_a_o,
    output logic [WIDTH-1:0] add_b_o,
    output logic             add_sub_o,
    input  logic [WIDTH-1:0] add_s_i,
    input  logic             add_cout_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             result_valid_o,
    output logic             digit_drop_o,
    output logic [WIDTH-1:0] disp_o
);

    localparam int EW = WIDTH + 4;
    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_EQ  = 4'd12;
    localparam logic [3:0] KEY_CLR = 4'd13;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        EXEC    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_a_reg;
    logic [WIDTH-1:0] acc_b_reg;
    logic             op_reg;
    logic             b_digit_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             result_valid_reg;
    logic             digit_drop_reg;

    logic [EW-1:0]    acc_sel;
    logic [EW-1:0]    acc_new;
    logic             digit_fits;
    logic             is_digit;
    logic             is_op;
    logic             key_fire;

    assign key_ready_o = (state_reg != EXEC);
    assign key_fire    = key_valid_i & key_ready_o;
    assign is_digit    = (key_code_i <= 4'd9);
    assign is_op       = (key_code_i == KEY_ADD) || (key_code_i == KEY_SUB);

    // Widened multiply-accumulate; any bit above WIDTH means the operand would overflow.
    assign acc_sel    = (state_reg == ENTER_B) ? {4'b0, acc_b_reg} : {4'b0, acc_a_reg};
    assign acc_new    = acc_sel * EW'(10) + EW'(key_code_i);
    assign digit_fits = (acc_new[EW-1:WIDTH] == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg        <= ENTER_A;
            acc_a_reg        <= '0;
            acc_b_reg        <= '0;
            op_reg           <= 1'b0;
            b_digit_reg      <= 1'b0;
            result_reg       <= '0;
            carry_reg        <= 1'b0;
            result_valid_reg <= 1'b0;
            digit_drop_reg   <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            digit_drop_reg   <= 1'b0;
            case (state_reg)
                ENTER_A: if (key_fire) begin
                    if (is_digit) begin
                        if (digit_fits) acc_a_reg <= acc_new[WIDTH-1:0];
                        else            digit_drop_reg <= 1'b1;
                    end else if (is_op) begin
                        op_reg      <= (key_code_i == KEY_SUB);
                        acc_b_reg   <= '0;
                        b_digit_reg <= 1'b0;
                        state_reg   <= ENTER_B;
                    end else if (key_code_i == KEY_CLR) begin
                        acc_a_reg <= '0;
                    end
                end
                ENTER_B: if (key_fire) begin
                    if (is_digit) begin
                        if (digit_fits) begin
                            acc_b_reg   <= acc_new[WIDTH-1:0];
                            b_digit_reg <= 1'b1;
                        end else begin
                            digit_drop_reg <= 1'b1;
                        end
                    end else if (is_op) begin
                        // Operator may only be corrected before B has any digits.
                        if (!b_digit_reg) op_reg <= (key_code_i == KEY_SUB);
                    end else if (key_code_i == KEY_EQ) begin
                        state_reg <= EXEC;
                    end else if (key_code_i == KEY_CLR) begin
                        acc_a_reg   <= '0;
                        acc_b_reg   <= '0;
                        op_reg      <= 1'b0;
                        b_digit_reg <= 1'b0;
                        result_reg  <= '0;
                        carry_reg   <= 1'b0;
                        state_reg   <= ENTER_A;
                    end
                end
                EXEC: begin
                    result_reg       <= add_s_i;
                    carry_reg        <= add_cout_i;
                    result_valid_reg <= 1'b1;
                    state_reg        <= DONE;
                end
                DONE: if (key_fire) begin
                    if (is_op) begin
                        acc_a_reg   <= result_reg;
                        op_reg      <= (key_code_i == KEY_SUB);
                        acc_b_reg   <= '0;
                        b_digit_reg <= 1'b0;
                        state_reg   <= ENTER_B;
                    end else if (is_digit) begin
                        acc_a_reg <= WIDTH'(key_code_i);
                        state_reg <= ENTER_A;
                    end else if (key_code_i == KEY_CLR) begin
                        acc_a_reg   <= '0;
                        acc_b_reg   <= '0;
                        op_reg      <= 1'b0;
                        b_digit_reg <= 1'b0;
                        result_reg  <= '0;
                        carry_reg   <= 1'b0;
                        state_reg   <= ENTER_A;
                    end
                end
                default: state_reg <= ENTER_A;
            endcase
        end
    end

    assign add_a_o        = acc_a_reg;
    assign add_b_o        = acc_b_reg;
    assign add_sub_o      = op_reg;
    assign result_o       = result_reg;
    assign carry_o        = carry_reg;
    assign result_valid_o = result_valid_reg;
    assign digit_drop_o   = digit_drop_reg;

    always_comb begin
        disp_o = result_reg;
        case (state_reg)
            ENTER_A: disp_o = acc_a_reg;
            ENTER_B: disp_o = acc_b_reg;
            default: disp_o = result_reg;
        endcase
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed key sequences plus random key streams, each
// checked against a transaction-level calculator model with an integer adder stand-in.
module tb_calc_entry_ctrl;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    localparam int PH_A    = 0;
    localparam int PH_B    = 1;
    localparam int PH_CALC = 2;
    localparam int PH_SHOW = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [3:0]   key_code = 4'd0;
    logic         key_ready;
    logic [W-1:0] add_a, add_b, add_s, result, disp;
    logic         add_sub, add_cout, carry, result_valid, digit_drop;

    calc_entry_ctrl #(.WIDTH(W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .key_valid_i    (key_valid),
        .key_code_i     (key_code),
        .key_ready_o    (key_ready),
        .add_a_o        (add_a),
        .add_b_o        (add_b),
        .add_sub_o      (add_sub),
        .add_s_i        (add_s),
        .add_cout_i     (add_cout),
        .result_o       (result),
        .carry_o        (carry),
        .result_valid_o (result_valid),
        .digit_drop_o   (digit_drop),
        .disp_o         (disp)
    );

    // Combinational adder/subtractor standing in for add_sub_nbits.
    assign {add_cout, add_s} = add_sub ? ({1'b0, add_a} - {1'b0, add_b})
                                       : ({1'b0, add_a} + {1'b0, add_b});

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int m_a, m_b, m_op, m_bdig, m_res, m_carry, m_phase, m_drop, m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_bdig = 0; m_res = 0; m_carry = 0;
        m_phase = PH_A; m_drop = 0; m_valid = 0;
    endtask

    task automatic model_clear_all();
        m_a = 0; m_b = 0; m_op = 0; m_bdig = 0; m_res = 0; m_carry = 0;
        m_phase = PH_A;
    endtask

    task automatic model_key(input int k);
        int n;
        m_drop = 0;
        m_valid = 0;
        case (m_phase)
            PH_A: begin
                if (k <= 9) begin
                    n = m_a * 10 + k;
                    if (n > MAXV) m_drop = 1; else m_a = n;
                end else if (k == 10 || k == 11) begin
                    m_op = (k == 11); m_b = 0; m_bdig = 0; m_phase = PH_B;
                end else if (k == 13) begin
                    m_a = 0;
                end
            end
            PH_B: begin
                if (k <= 9) begin
                    n = m_b * 10 + k;
                    if (n > MAXV) m_drop = 1; else begin m_b = n; m_bdig = 1; end
                end else if (k == 10 || k == 11) begin
                    if (m_bdig == 0) m_op = (k == 11);
                end else if (k == 12) begin
                    m_phase = PH_CALC;
                end else if (k == 13) begin
                    model_clear_all();
                end
            end
            PH_SHOW: begin
                if (k == 10 || k == 11) begin
                    m_a = m_res; m_op = (k == 11); m_b = 0; m_bdig = 0; m_phase = PH_B;
                end else if (k <= 9) begin
                    m_a = k; m_phase = PH_A;
                end else if (k == 13) begin
                    model_clear_all();
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_exec();
        m_drop = 0;
        if (m_op != 0) begin
            m_carry = (m_a < m_b) ? 1 : 0;
            m_res = (m_a - m_b + MAXV + 1) % (MAXV + 1);
        end else begin
            m_carry = (m_a + m_b > MAXV) ? 1 : 0;
            m_res = (m_a + m_b) % (MAXV + 1);
        end
        m_valid = 1;
        m_phase = PH_SHOW;
    endtask

    task automatic check_all(input string tag);
        int exp_disp;
        exp_disp = (m_phase == PH_A) ? m_a : (m_phase == PH_B) ? m_b : m_res;
        chk({tag, ".disp"},   32'(disp),         32'(exp_disp));
        chk({tag, ".ready"},  32'(key_ready),    32'(m_phase != PH_CALC));
        chk({tag, ".drop"},   32'(digit_drop),   32'(m_drop));
        chk({tag, ".valid"},  32'(result_valid), 32'(m_valid));
        chk({tag, ".result"}, 32'(result),       32'(m_res));
        chk({tag, ".carry"},  32'(carry),        32'(m_carry));
        chk({tag, ".add_a"},  32'(add_a),        32'(m_a));
        chk({tag, ".add_b"},  32'(add_b),        32'(m_b));
        chk({tag, ".sub"},    32'(add_sub),      32'(m_op));
    endtask

    // One key per edge; an accepted '=' is followed by the EXEC edge.
    task automatic press(input int k);
        key_valid = 1'b1;
        key_code  = 4'(k);
        @(posedge clk); #1;
        key_valid = 1'b0;
        model_key(k);
        check_all($sformatf("key%0d", k));
        if (m_phase == PH_CALC) begin
            @(posedge clk); #1;
            model_exec();
            check_all("exec");
        end
    endtask

    task automatic press_seq(input int keys[$]);
        foreach (keys[i]) press(keys[i]);
    endtask

    initial begin
        int r;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("idle");

        press_seq('{1, 2, 10, 3, 4, 12});
        chk("sum46", 32'(result), 32'd46);
        chk("sum46.carry", 32'(carry), 32'd0);
        @(posedge clk); #1;
        chk("sum46.pulse_end", 32'(result_valid), 32'd0);

        press_seq('{10, 4, 12});
        chk("chain50", 32'(result), 32'd50);
        press(13);
        chk("clear.disp", 32'(disp), 32'd0);

        press_seq('{5, 11, 7, 12});
        chk("borrow", 32'(result), 32'hFE);
        chk("borrow.carry", 32'(carry), 32'd1);

        press_seq('{2, 0, 0, 10, 1, 0, 0, 12});
        chk("ovf44", 32'(result), 32'd44);
        chk("ovf44.carry", 32'(carry), 32'd1);

        press_seq('{13, 2, 5});
        press(6);
        chk("drop.pulse", 32'(digit_drop), 32'd1);
        chk("drop.acc", 32'(add_a), 32'd25);
        press_seq('{10, 1, 12});
        chk("sum26", 32'(result), 32'd26);

        // '+' offered during EXEC must wait for key_ready.
        press_seq('{13, 9, 10, 9});
        key_valid = 1'b1; key_code = 4'd12;
        @(posedge clk); #1;
        model_key(12);
        check_all("held.eq");
        key_code = 4'd10;
        @(posedge clk); #1;
        model_exec();
        check_all("held.exec");
        @(posedge clk); #1;
        key_valid = 1'b0;
        model_key(10);
        check_all("held.take");
        chk("held.chain_a", 32'(add_a), 32'd18);

        // Reset asserted while EXEC is in progress.
        press(3);
        key_valid = 1'b1; key_code = 4'd12;
        @(posedge clk); #1;
        key_valid = 1'b0;
        model_key(12);
        check_all("rexec.eq");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rexec.async");
        @(posedge clk); #1;
        check_all("rexec.hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("rexec.after");

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      press($urandom_range(0, 9));
            else if (r < 75) press(10);
            else if (r < 85) press(11);
            else if (r < 95) press(12);
            else if (r < 98) press(13);
            else             press($urandom_range(14, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
